// File: rtl/rst_seq_if.sv
// rst_seq_if: request inputs and staged reset outputs of the reset sequencer
interface rst_seq_if #(
    parameter int NUM_STAGES = 3
);
    logic                  pb_n;
    logic                  sw_rst_req;
    logic                  wdog_en;
    logic                  wdog_kick;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  busy;
    logic [1:0]            cause;
    logic                  wdog_expired;

    modport master (
        output pb_n, sw_rst_req, wdog_en, wdog_kick,
        input  stage_rst_n, busy, cause, wdog_expired
    );

    modport slave (
        input  pb_n, sw_rst_req, wdog_en, wdog_kick,
        output stage_rst_n, busy, cause, wdog_expired
    );
endinterface

// File: rtl/rst_seq.sv
// rst_seq: reset sequencer with staged, ordered releases, watchdog and cause report
module rst_seq #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int NUM_STAGES  = 3,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    rst_seq_if.slave    bus
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = STAGE_GAP > 1 ? $clog2(STAGE_GAP) : 1;
    localparam int WW = $clog2(WDOG_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(STAGE_GAP - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(WDOG_CYCLES - 1);

    typedef enum logic [1:0] {S_ASSERT, S_STAGE, S_RUN} state_t;

    state_t                state_q, state_n;
    logic [HW-1:0]         hold_q, hold_n;
    logic [GW-1:0]         gap_q, gap_n;
    logic [WW-1:0]         wd_q, wd_n;
    logic [NUM_STAGES-1:0] stage_q, stage_n, stage_shift;
    logic                  busy_q, busy_n;
    logic [1:0]            cause_q, cause_n;
    logic                  exp_q, exp_n;
    logic                  pb_s1, pb_s2;
    logic                  pb_req, wd_count, wd_timeout, trig;

    assign bus.stage_rst_n  = stage_q;
    assign bus.busy         = busy_q;
    assign bus.cause        = cause_q;
    assign bus.wdog_expired = exp_q;

    // two-flop synchronizer for the asynchronous push button, idles released
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_s1 <= 1'b1;
            pb_s2 <= 1'b1;
        end else begin
            pb_s1 <= bus.pb_n;
            pb_s2 <= pb_s1;
        end
    end

    // sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ASSERT;
            hold_q  <= '0;
            gap_q   <= '0;
            wd_q    <= '0;
            stage_q <= '0;
            busy_q  <= 1'b1;
            cause_q <= 2'd0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            hold_q  <= hold_n;
            gap_q   <= gap_n;
            wd_q    <= wd_n;
            stage_q <= stage_n;
            busy_q  <= busy_n;
            cause_q <= cause_n;
            exp_q   <= exp_n;
        end
    end

    assign pb_req      = ~pb_s2;
    assign wd_count    = state_q == S_RUN && bus.wdog_en && !bus.wdog_kick;
    assign wd_timeout  = wd_count && wd_q == WD_MAX;
    assign trig        = pb_req | wd_timeout | bus.sw_rst_req;
    assign stage_shift = (stage_q << 1) | NUM_STAGES'(1);

    // next state: any trigger restarts the hold, otherwise hold then release stages in order
    always_comb begin
        state_n = state_q;
        hold_n  = hold_q;
        gap_n   = gap_q;
        stage_n = stage_q;
        busy_n  = busy_q;
        cause_n = cause_q;
        exp_n   = 1'b0;
        wd_n    = wd_count && !wd_timeout ? wd_q + WW'(1) : '0;
        if (trig) begin
            state_n = S_ASSERT;
            hold_n  = '0;
            gap_n   = '0;
            stage_n = '0;
            busy_n  = 1'b1;
            cause_n = pb_req ? 2'd1 : wd_timeout ? 2'd2 : 2'd3;
            exp_n   = wd_timeout;
        end else if (state_q == S_ASSERT) begin
            hold_n = hold_q == HOLD_MAX ? '0 : hold_q + HW'(1);
            if (hold_q == HOLD_MAX) begin
                gap_n   = '0;
                stage_n = NUM_STAGES'(1);
                state_n = NUM_STAGES == 1 ? S_RUN : S_STAGE;
                busy_n  = NUM_STAGES != 1;
            end
        end else if (state_q == S_STAGE) begin
            gap_n = gap_q == GAP_MAX ? '0 : gap_q + GW'(1);
            if (gap_q == GAP_MAX) begin
                stage_n = stage_shift;
                state_n = &stage_shift ? S_RUN : S_STAGE;
                busy_n  = ~&stage_shift;
            end
        end
    end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed vectors for the reset sequencer (watchdog shortened to 32 cycles)
module tb_rst_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    rst_seq_if #(.NUM_STAGES(3)) bus ();

    rst_seq #(
        .HOLD_CYCLES(16),
        .STAGE_GAP  (4),
        .NUM_STAGES (3),
        .WDOG_CYCLES(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] st, input logic bz, input logic [1:0] cs);
        chk({tag, ".stage"}, 32'(bus.stage_rst_n), 32'(st));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(bz));
        chk({tag, ".cause"}, 32'(bus.cause), 32'(cs));
    endtask

    initial begin
        bus.pb_n = 1'b1;
        bus.sw_rst_req = 1'b0;
        bus.wdog_en = 1'b0;
        bus.wdog_kick = 1'b0;
        // power-on release
        tick(3);
        chk_out("por_T0", 3'b000, 1'b1, 2'd0);
        chk("por_T0.exp", 32'(bus.wdog_expired), 0);
        rst = 1'b0;
        tick(15);  chk_out("por_T15", 3'b000, 1'b1, 2'd0);
        tick(1);   chk_out("por_T16", 3'b001, 1'b1, 2'd0);
        tick(3);   chk_out("por_T19", 3'b001, 1'b1, 2'd0);
        tick(1);   chk_out("por_T20", 3'b011, 1'b1, 2'd0);
        tick(3);   chk_out("por_T23", 3'b011, 1'b1, 2'd0);
        tick(1);   chk_out("por_T24", 3'b111, 1'b0, 2'd0);
        // watchdog expiry 32 edges after RUN entry
        bus.wdog_en = 1'b1;
        tick(31);  chk("wd_31.exp", 32'(bus.wdog_expired), 0);
        chk_out("wd_31", 3'b111, 1'b0, 2'd0);
        tick(1);   chk("wd_32.exp", 32'(bus.wdog_expired), 1);
        chk_out("wd_32", 3'b000, 1'b1, 2'd2);
        bus.wdog_en = 1'b0;
        tick(1);   chk("wd_33.exp", 32'(bus.wdog_expired), 0);
        tick(23);  chk_out("wd_rel", 3'b111, 1'b0, 2'd2);
        // regular kicks keep it alive, then a kick on the timeout cycle wins
        bus.wdog_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(19);
            bus.wdog_kick = 1'b1;
            tick(1);
            bus.wdog_kick = 1'b0;
            chk("kick.exp", 32'(bus.wdog_expired), 0);
        end
        chk_out("kick", 3'b111, 1'b0, 2'd2);
        tick(31);
        bus.wdog_kick = 1'b1;
        tick(1);
        bus.wdog_kick = 1'b0;
        chk("kick_to.exp", 32'(bus.wdog_expired), 0);
        chk_out("kick_to", 3'b111, 1'b0, 2'd2);
        bus.wdog_en = 1'b0;
        tick(1);
        // single-cycle push button, two-edge synchronizer latency
        bus.pb_n = 1'b0;
        tick(1);
        bus.pb_n = 1'b1;
        chk_out("pb_k", 3'b111, 1'b0, 2'd2);
        tick(1);   chk_out("pb_k1", 3'b111, 1'b0, 2'd2);
        tick(1);   chk_out("pb_k2", 3'b000, 1'b1, 2'd1);
        tick(23);  chk_out("pb_k25", 3'b011, 1'b1, 2'd1);
        tick(1);   chk_out("pb_k26", 3'b111, 1'b0, 2'd1);
        // held button: last trigger at k+51, bit 0 at k+67
        bus.pb_n = 1'b0;
        tick(50);
        bus.pb_n = 1'b1;
        tick(2);   chk_out("pbh_k51", 3'b000, 1'b1, 2'd1);
        tick(15);  chk_out("pbh_k66", 3'b000, 1'b1, 2'd1);
        tick(1);   chk_out("pbh_k67", 3'b001, 1'b1, 2'd1);
        tick(8);   chk_out("pbh_rel", 3'b111, 1'b0, 2'd1);
        // push button beats software on the same edge
        bus.pb_n = 1'b0;
        tick(1);
        bus.pb_n = 1'b1;
        tick(1);
        bus.sw_rst_req = 1'b1;
        tick(1);
        bus.sw_rst_req = 1'b0;
        chk_out("pb_sw", 3'b000, 1'b1, 2'd1);
        tick(24);  chk_out("pb_sw_rel", 3'b111, 1'b0, 2'd1);
        // watchdog beats software on the same edge
        bus.wdog_en = 1'b1;
        tick(31);
        bus.sw_rst_req = 1'b1;
        tick(1);
        bus.sw_rst_req = 1'b0;
        bus.wdog_en = 1'b0;
        chk_out("wd_sw", 3'b000, 1'b1, 2'd2);
        chk("wd_sw.exp", 32'(bus.wdog_expired), 1);
        // software restart after stage 0 released
        tick(17);  chk_out("mid_T17", 3'b001, 1'b1, 2'd2);
        bus.sw_rst_req = 1'b1;
        tick(1);
        bus.sw_rst_req = 1'b0;
        chk_out("mid_T18", 3'b000, 1'b1, 2'd3);
        tick(15);  chk_out("mid_T33", 3'b000, 1'b1, 2'd3);
        tick(1);   chk_out("mid_T34", 3'b001, 1'b1, 2'd3);
        tick(4);   chk_out("mid_T38", 3'b011, 1'b1, 2'd3);
        // rst mid-sequence
        rst = 1'b1;
        tick(1);   chk_out("rst_mid", 3'b000, 1'b1, 2'd0);
        rst = 1'b0;
        tick(16);  chk_out("rst_T16", 3'b001, 1'b1, 2'd0);
        tick(8);   chk_out("rst_T24", 3'b111, 1'b0, 2'd0);
        // software request held several cycles
        bus.sw_rst_req = 1'b1;
        tick(5);
        bus.sw_rst_req = 1'b0;
        chk_out("swh_5", 3'b000, 1'b1, 2'd3);
        tick(15);  chk_out("swh_20", 3'b000, 1'b1, 2'd3);
        tick(1);   chk_out("swh_21", 3'b001, 1'b1, 2'd3);
        tick(8);   chk_out("swh_rel", 3'b111, 1'b0, 2'd3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
- Reset sequencer and watchdog. Generates the design's staged synchronous reset releases from three sources: power-on (`rst`), the raw push button, and a software request, plus an internal watchdog.
- Complements the input-side reset synchronizer. That block cleans a reset coming in; this block originates, stretches and orders the resets that go out to downstream domains (e.g. sensor interface, then balance control, then motor drive).
- Also reports the last reset cause.

Parameters:
- `HOLD_CYCLES`, 16, cycles all stages stay asserted after any trigger (>=1).
- `STAGE_GAP`, 4, cycles between successive stage releases (>=1).
- `NUM_STAGES`, 3, number of staged reset outputs (1..8).
- `WDOG_CYCLES`, 1024, watchdog timeout in cycles (>=2).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset (power-on source).
- `pb_n`  in  1  raw push-button reset request, active-low, asynchronous to `clk`.
- `sw_rst_req`  in  1  single-cycle software reset request.
- `wdog_en`  in  1  watchdog enable.
- `wdog_kick`  in  1  watchdog service pulse.
- `stage_rst_n`  out  NUM_STAGES  per-stage reset, active-low; bit 0 is released first.
- `busy`  out  1  high while any stage is asserted.
- `cause`  out  2  last reset cause: 0 = POR, 1 = PB, 2 = WDOG, 3 = SW.
- `wdog_expired`  out  1  one-cycle pulse on watchdog timeout.

Behaviour:
- All outputs are registered. While `rst`=1 at an edge:
  - state = ASSERT, `stage_rst_n` = 0, `busy` = 1, `cause` = 0, `wdog_expired` = 0;
  - hold/stage/watchdog counters = 0;
  - `pb_n` synchronizer flops preset to 1.
- `pb_n` passes through a 2-flop synchronizer. `pb_req` = synchronized value == 0. A `pb_n` low sampled at edge k gives `pb_req`=1 after edge k+1; outputs respond at edge k+2.
- Trigger = `pb_req` | `wd_timeout` | `sw_rst_req`, evaluated in every state.
- Cause priority when triggers coincide: PB > WDOG > SW.
- Any trigger at edge T:
  - state -> ASSERT, all `stage_rst_n` = 0, `busy` = 1;
  - hold counter cleared; `cause` updated at the same edge.
- A trigger in ASSERT or STAGE restarts the hold. A held button therefore keeps all stages asserted indefinitely.
- States:
  - ASSERT: the hold counter counts edges. After HOLD_CYCLES edges with no trigger -> STAGE. Bit 0 is released at the transition edge.
  - STAGE: bit i is released STAGE_GAP edges after bit i-1. Released bits stay 1 until the next trigger. When bit NUM_STAGES-1 is released: `busy` goes 0 on that same edge, state -> RUN.
  - RUN: all `stage_rst_n` = 1, `busy` = 0.
- Release timing: with the last trigger/`rst` edge at T0, bit i rises at edge T0 + HOLD_CYCLES + i*STAGE_GAP. If NUM_STAGES=1, `busy` falls at T0 + HOLD_CYCLES.
- Watchdog:
  - counts only in RUN with `wdog_en`=1;
  - cleared when `wdog_kick`=1, `wdog_en`=0, or the state is not RUN.
  - `wd_timeout` = counter == WDOG_CYCLES-1 and `wdog_kick`=0. Kick wins over a same-cycle timeout.
  - On timeout: `wdog_expired` pulses 1 for exactly one cycle (the trigger edge), the counter clears, and a WDOG trigger occurs.
- Counter widths: $clog2 of each limit. No wrap is possible because each counter clears on reaching its limit.
- `rst` overrides everything, including a mid-sequence trigger. `cause` returns to 0 (POR).
- `sw_rst_req` held high for multiple cycles acts as a repeated trigger (reset held).

Test Plan:
- POR release (defaults): `rst`=1 for 3 cycles, last `rst` edge at T0, then deassert -> `stage_rst_n` = 000 until T0+16; 001 at T0+16, 011 at T0+20, 111 at T0+24; `busy` falls at T0+24; `cause` = 0.
- Push button: in RUN, drive `pb_n` low at edge k for 1 cycle -> `stage_rst_n` = 000 at k+2, `cause` = 1, full release 24 edges later. Hold `pb_n` low 50 cycles -> stages stay 000 until 16 edges after the last `pb_req`.
- Watchdog (WDOG_CYCLES=32): `wdog_en`=1 in RUN with no kicks -> `wdog_expired` pulses 1 cycle exactly 32 edges after RUN entry, stages go 000 the same edge, `cause` = 2. Kicking every 20 cycles -> never expires. Kick on the timeout cycle -> no expiry.
- Simultaneous triggers: `sw_rst_req` and `pb_req` coincide -> `cause` = 1; WDOG+SW together -> `cause` = 2.
- Mid-sequence restart: `sw_rst_req` at T0+18 (stage 0 released) -> all stages 000 at T0+18, `cause` = 3, bit 0 rises at T0+34.
- `rst` during STAGE -> immediate 000, `cause` = 0, sequence restarts from the `rst` deassert.
